// File: rtl/denise_pkg.sv
// Shared definitions for the Denise bitplane sequencer: the load-sequencer states
// and the plane geometry constants.
package denise_pkg;

    localparam int PLANE_W    = 64;
    localparam int MAX_PLANES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOAD  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/denise_bpl_holding_buf.sv
// One bitplane holding register. It captures a data word on write and is
// cleared by a start-of-line flush.
module denise_bpl_holding_buf
    import denise_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr,
    input  logic               clr,
    input  logic [PLANE_W-1:0] d,
    output logic [PLANE_W-1:0] q
);

    // NOTE: the buffer is built from discrete flops, so it can be cleared by reset.
    // A RAM-mapped array could not be reset this way.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (wr) begin
            q <= d;
        end
    end

endmodule

// File: rtl/denise_bitplane_sequencer.sv
// Collects bitplane data words into holding buffers. A BPL1DAT write arms a
// parallel load, and the load transfers all planes and the scroll values together.
module denise_bitplane_sequencer
    import denise_pkg::*;
#(
    parameter int NPLANES = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clk7_en,
    input  logic                       c1,
    input  logic                       c3,
    input  logic                       dat_wr,
    input  logic [2:0]                 dat_sel,
    input  logic [PLANE_W-1:0]         dat_in,
    input  logic                       con1_wr,
    input  logic [15:0]                con1_in,
    input  logic [3:0]                 nplanes,
    input  logic                       line_start,
    output logic                       load,
    output logic [NPLANES*PLANE_W-1:0] plane_data,
    output logic [7:0]                 scroll_odd,
    output logic [7:0]                 scroll_even,
    output logic                       overrun
);

    seq_state_e         state;
    seq_state_e         state_nxt;
    logic [PLANE_W-1:0] hold [NPLANES];
    logic [15:0]        shadow;
    logic [3:0]         eff_planes;
    logic               dat_we;
    logic               plane0_wr;
    logic               c_zero;
    logic               xfer;

    // A start-of-line flush drops any coinciding data write.
    assign dat_we     = dat_wr && clk7_en && !line_start && (int'(dat_sel) < NPLANES);
    assign plane0_wr  = dat_we && (dat_sel == 3'd0);
    assign c_zero     = !c1 && !c3;
    assign xfer       = (state == ARMED) && c_zero && !line_start;
    assign eff_planes = (int'(nplanes) > NPLANES) ? 4'(NPLANES) : nplanes;
    assign load       = (state == ARMED) || (state == LOAD);

    for (genvar g = 0; g < NPLANES; g++) begin : g_buf
        denise_bpl_holding_buf u_buf (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (dat_we && (dat_sel == 3'(g))),
            .clr     (line_start),
            .d       (dat_in),
            .q       (hold[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments. Every register then
    // updates from the values it had before the edge, whatever the block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is assigned a default first, so no path through this block
    // leaves it unassigned. This avoids an inferred latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (plane0_wr) state_nxt = ARMED;
            ARMED:   if (c_zero)    state_nxt = LOAD;
            LOAD:    state_nxt = plane0_wr ? ARMED : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (line_start) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plane_data  <= '0;
            scroll_odd  <= '0;
            scroll_even <= '0;
        end else if (xfer) begin
            for (int n = 0; n < NPLANES; n++) begin
                plane_data[n*PLANE_W +: PLANE_W] <= (n < int'(eff_planes)) ? hold[n] : '0;
            end
            scroll_odd  <= shadow[7:0];
            scroll_even <= shadow[15:8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (con1_wr && clk7_en) begin
            shadow <= con1_in;
        end
    end

    // A new BPL1DAT word while a transfer is still pending means the old word was lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (line_start) begin
            overrun <= 1'b0;
        end else if ((state == ARMED) && plane0_wr) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: doc/denise_bitplane_sequencer.md
DENISE_BITPLANE_SEQUENCER -- requirements
Module: denise_bitplane_sequencer

Interface
REQ-001 SHALL have parameter NPLANES, default 8, meaning the number of bitplanes sequenced (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: 28 MHz pixel clock, the only clock.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port clk7_en, input, 1 bit: 7 MHz enable; register writes are qualified by it.
REQ-005 SHALL have ports c1 and c3, input, 1 bit each: bus phase clocks, as supplied to the shifters.
REQ-006 SHALL have port dat_wr, input, 1 bit: bitplane data write strobe.
REQ-007 SHALL have port dat_sel, input, 3 bits: plane index, 0 = BPL1DAT.
REQ-008 SHALL have port dat_in, input, 64 bits: bitplane data word.
REQ-009 SHALL have port con1_wr, input, 1 bit: scroll register write strobe.
REQ-010 SHALL have port con1_in, input, 16 bits: [7:0] odd-plane scroll, [15:8] even-plane scroll.
REQ-011 SHALL have port nplanes, input, 4 bits: active plane count, 0..NPLANES.
REQ-012 SHALL have port line_start, input, 1 bit: start-of-line flush.
REQ-013 SHALL have port load, output, 1 bit: parallel-load strobe to all shifters.
REQ-014 SHALL have port plane_data, output, NPLANES x 64 bits: per-plane load words.
REQ-015 SHALL have ports scroll_odd and scroll_even, output, 8 bits each: latched scroll values.
REQ-016 SHALL have port overrun, output, 1 bit: sticky flag for a BPL1DAT write made while a load is still pending.

Function
REQ-017 A write SHALL occur when dat_wr && clk7_en; dat_in goes into holding buffer dat_sel; a write with dat_sel >= NPLANES SHALL be ignored.
REQ-018 A con1 write SHALL occur when con1_wr && clk7_en; con1_in goes into a shadow register only, never directly to the scroll outputs.
REQ-019 The FSM SHALL have three states: IDLE, ARMED and LOAD.
REQ-020 IDLE -> ARMED SHALL occur on a plane-0 write, effective the next clk.
REQ-021 ARMED -> LOAD SHALL occur on the first clk edge where c1==0 and c3==0.
REQ-022 LOAD SHALL last exactly one clk, then return to IDLE, or to ARMED if a plane-0 write occurs in that same cycle.
REQ-023 load SHALL be 1 in both ARMED and LOAD, so the shifters see load high with c1=c3=0 exactly once per arm.
REQ-024 On the ARMED -> LOAD edge, plane_data[n] SHALL take holding buffer n for n < nplanes, and 0 for n >= nplanes.
REQ-025 On the same edge, scroll_odd/scroll_even SHALL take shadow[7:0]/shadow[15:8].
REQ-026 Latency: a plane-0 write in the cycle where c1=c3=0 next occurs 4 clk later SHALL produce load high for 5 clk and outputs updated on the 5th edge.
REQ-027 A write to plane n in the ARMED cycle before the transfer edge SHALL be included in that transfer; a write on the transfer edge itself SHALL land in the buffer only.
REQ-028 A plane-0 write while ARMED SHALL set overrun, keep ARMED, and let the new data replace the old.
REQ-029 overrun SHALL be cleared only by line_start or by reset.
REQ-030 line_start SHALL force IDLE, clear overrun and clear all holding buffers.
REQ-031 line_start SHALL NOT alter plane_data or the scroll outputs.
REQ-032 If line_start and a write coincide, line_start SHALL win and the write is dropped.
REQ-033 A nplanes value greater than NPLANES SHALL be treated as NPLANES.

Reset
REQ-034 Asserting reset_n low SHALL asynchronously set state=IDLE, load=0, plane_data=0, scroll_odd=scroll_even=0, overrun=0, and clear all buffers and the shadow register.
REQ-035 Reset released mid-operation SHALL restart from IDLE; any pending arm is lost.

Structure
REQ-036 A shared package denise_pkg SHALL hold the FSM state enumeration (IDLE, ARMED, LOAD), the plane word width constant (64) and the maximum plane count constant (8).
REQ-037 There SHALL be one sub-module, denise_bpl_holding_buf: a single 64-bit holding register with write and clear, instantiated NPLANES times.
REQ-038 All logic SHALL be in the clk domain; there SHALL be no combinational path from dat_in to plane_data.

Verification
REQ-039 Write planes 1..3 then plane 0 with nplanes=4, c1=c3=0 occurring 3 clk later -> load high for 4 clk; plane_data[0..3] match the written words; plane_data[4..7]=0.
REQ-040 con1 write 0x3412 then a plane-0 write -> scroll_odd=0x12 and scroll_even=0x34 only on the transfer edge, unchanged before it.
REQ-041 Two plane-0 writes before any c1=c3=0 cycle -> overrun=1; one load; plane_data[0] = second word.
REQ-042 Plane-0 write coinciding with line_start -> state IDLE, no load, overrun=0, buffers zero.
REQ-043 Plane-0 write on the LOAD edge -> load stays high and a second transfer occurs at the next c1=c3=0 cycle carrying the new word.
REQ-044 reset_n low while ARMED -> load=0 immediately without waiting for a clk edge; all outputs 0.
